// File: rtl/fret_hit_scorer_pkg.sv
// Shared types and constants for the fret hit scorer: lane identities, key map,
// scoring constants, judge FSM encodings and the multiplier helper.
package fret_hit_scorer_pkg;

   localparam int NUM_LANES  = 5;
   localparam int HIT_POINTS = 10;
   localparam int MULT_MAX   = 4;
   localparam int STREAK_W   = 7;
   localparam int MULT_W     = 3;
   localparam int LANE_W     = 3;
   localparam int Y_W        = 10;

   typedef enum logic [2:0] {
      LANE_GREEN  = 3'd0,
      LANE_RED    = 3'd1,
      LANE_YELLOW = 3'd2,
      LANE_BLUE   = 3'd3,
      LANE_ORANGE = 3'd4
   } lane_e;

   localparam logic [7:0] LANE_KEYCODE [NUM_LANES] = '{8'h04, 8'h16, 8'h07, 8'h09, 8'h0A};

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      JUDGE = 1'b1
   } judge_state_e;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_JUDGE = 1'b1;

   // min(MULT_MAX, 1 + streak/10)
   function automatic logic [MULT_W-1:0] mult_of(input logic [STREAK_W-1:0] streak);
      logic [STREAK_W-1:0] tens;
      tens = streak / 7'd10;
      if (tens >= 7'(MULT_MAX - 1)) begin
         return 3'(MULT_MAX);
      end else begin
         return 3'(tens) + 3'd1;
      end
   endfunction

endpackage

// File: rtl/fret_hit_scorer_if.sv
// Bundle between the keyboard/sprite stage and the scorer: key and note inputs,
// per-lane pulses and the score/streak/multiplier readout.
interface fret_hit_scorer_if #(
   parameter int NUM_LANES = 5,
   parameter int SCORE_W   = 16
);
   logic [7:0]             keycode;
   logic [NUM_LANES*10-1:0] note_y;
   logic [NUM_LANES-1:0]   note_valid;
   logic [NUM_LANES-1:0]   hit_pulse;
   logic [NUM_LANES-1:0]   miss_pulse;
   logic [SCORE_W-1:0]     score;
   logic [6:0]             streak;
   logic [2:0]             multiplier;
   logic                   busy;

   modport master (
      output keycode, note_y, note_valid,
      input  hit_pulse, miss_pulse, score, streak, multiplier, busy
   );

   modport slave (
      input  keycode, note_y, note_valid,
      output hit_pulse, miss_pulse, score, streak, multiplier, busy
   );
endinterface

// File: rtl/fret_hit_scorer_frame_tick_sync.sv
// Brings VGA vertical sync into the Clk domain and emits a one-cycle tick on its
// rising edge, three Clk cycles after the VS rise.
module frame_tick_sync (
   input  logic Clk,
   input  logic Reset,
   input  logic async_in,
   output logic tick
);

   logic meta_r;
   logic sync_r;
   logic prev_r;
   logic tick_r;

   // two-flop synchronizer, then a registered rising-edge detect
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
         prev_r <= 1'b0;
         tick_r <= 1'b0;
      end else begin
         meta_r <= async_in;
         sync_r <= meta_r;
         prev_r <= sync_r;
         tick_r <= sync_r & ~prev_r;
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/fret_hit_scorer.sv
// Judges key presses against falling notes once per frame, one lane per cycle,
// and maintains score, streak and multiplier.
module fret_hit_scorer
   import fret_hit_scorer_pkg::*;
#(
   parameter int ZONE_TOP   = 400,
   parameter int ZONE_BOT   = 440,
   parameter int MISS_Y     = 460,
   parameter int SCORE_W    = 16,
   parameter int STREAK_MAX = 99
) (
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   fret_hit_scorer_if.slave bus
);

   logic                  tick_s;
   logic [NUM_LANES-1:0]  key_hit_s;
   logic [NUM_LANES-1:0]  press_s;
   logic [NUM_LANES-1:0]  inzone_s;
   logic [NUM_LANES-1:0]  beyond_s;
   logic [NUM_LANES-1:0]  fresh_s;
   logic [NUM_LANES-1:0]  sel_s;
   logic [NUM_LANES-1:0]  prev_r;
   logic [NUM_LANES-1:0]  pending_r;
   logic [NUM_LANES-1:0]  consumed_r;
   logic [NUM_LANES-1:0]  passed_r;

   logic [0:0]            state_r;
   logic                  busy_r;
   logic [LANE_W-1:0]     lane_cnt_r;
   logic [NUM_LANES-1:0]  hit_pulse_r;
   logic [NUM_LANES-1:0]  miss_pulse_r;
   logic [SCORE_W-1:0]    score_r;
   logic [STREAK_W-1:0]   streak_r;
   logic [MULT_W-1:0]     mult_r;

   logic                  judging_s;
   logic                  hit_s;
   logic                  bad_s;
   logic                  pass_s;
   logic [6:0]            points_s;
   logic [SCORE_W:0]      sum_s;
   logic [SCORE_W-1:0]    score_next_s;
   logic [STREAK_W-1:0]   streak_next_s;

   frame_tick_sync u_tick (
      .Clk      (Clk),
      .Reset    (Reset),
      .async_in (frame_clk),
      .tick     (tick_s)
   );

   // per-lane key decode, note position classification and judge-lane select
   always_comb begin
      key_hit_s = '0;
      press_s   = '0;
      inzone_s  = '0;
      beyond_s  = '0;
      fresh_s   = '0;
      sel_s     = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         key_hit_s[i] = (bus.keycode == LANE_KEYCODE[i]);
         press_s[i]   = key_hit_s[i] & ~prev_r[i];
         inzone_s[i]  = bus.note_valid[i]
                        & (bus.note_y[Y_W*i +: Y_W] >= 10'(ZONE_TOP))
                        & (bus.note_y[Y_W*i +: Y_W] <= 10'(ZONE_BOT));
         beyond_s[i]  = bus.note_valid[i] & (bus.note_y[Y_W*i +: Y_W] > 10'(MISS_Y));
         fresh_s[i]   = ~bus.note_valid[i] | (bus.note_y[Y_W*i +: Y_W] < 10'(ZONE_TOP));
         sel_s[i]     = (lane_cnt_r == 3'(i));
      end
   end

   // verdict for the lane under judgement this cycle
   always_comb begin
      judging_s = (state_r == ST_JUDGE);
      hit_s     = 1'b0;
      bad_s     = 1'b0;
      pass_s    = 1'b0;
      if (judging_s) begin
         if (|(sel_s & pending_r & inzone_s & ~consumed_r)) begin
            hit_s = 1'b1;
         end else if (|(sel_s & pending_r)) begin
            bad_s = 1'b1;
         end else if (|(sel_s & beyond_s & ~consumed_r & ~passed_r)) begin
            pass_s = 1'b1;
         end else begin
            hit_s = 1'b0;
         end
      end else begin
         hit_s = 1'b0;
      end
   end

   // saturating score add and streak update; multiplier comes from the pre-hit streak
   always_comb begin
      points_s      = {4'b0000, mult_r} * 7'd10;
      sum_s         = {1'b0, score_r} + (SCORE_W+1)'(points_s);
      score_next_s  = score_r;
      streak_next_s = streak_r;
      if (hit_s) begin
         score_next_s = sum_s[SCORE_W] ? {SCORE_W{1'b1}} : sum_s[SCORE_W-1:0];
         if (streak_r >= 7'(STREAK_MAX)) begin
            streak_next_s = 7'(STREAK_MAX);
         end else begin
            streak_next_s = streak_r + 7'd1;
         end
      end else if (bad_s | pass_s) begin
         streak_next_s = 7'd0;
      end else begin
         streak_next_s = streak_r;
      end
   end

   // press history and the pending/consumed/passed flag arrays
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         prev_r     <= '0;
         pending_r  <= '0;
         consumed_r <= '0;
         passed_r   <= '0;
      end else begin
         prev_r <= key_hit_s;
         for (int i = 0; i < NUM_LANES; i++) begin
            // a fresh press wins over the judge's clear so it survives to the next frame
            pending_r[i] <= press_s[i] | (pending_r[i] & ~(judging_s & sel_s[i]));
            if (fresh_s[i]) begin
               consumed_r[i] <= 1'b0;
               passed_r[i]   <= 1'b0;
            end else begin
               if (hit_s & sel_s[i]) begin
                  consumed_r[i] <= 1'b1;
               end
               if (pass_s & sel_s[i]) begin
                  passed_r[i] <= 1'b1;
               end
            end
         end
      end
   end

   // judge FSM: one lane per cycle after each frame tick; ticks while judging are dropped
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r    <= ST_IDLE;
         busy_r     <= 1'b0;
         lane_cnt_r <= 3'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               lane_cnt_r <= 3'd0;
               if (tick_s) begin
                  state_r <= ST_JUDGE;
                  busy_r  <= 1'b1;
               end
            end
            ST_JUDGE: begin
               if (lane_cnt_r == 3'(NUM_LANES - 1)) begin
                  state_r    <= ST_IDLE;
                  busy_r     <= 1'b0;
                  lane_cnt_r <= 3'd0;
               end else begin
                  lane_cnt_r <= lane_cnt_r + 3'd1;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               busy_r     <= 1'b0;
               lane_cnt_r <= 3'd0;
            end
         endcase
      end
   end

   // registered pulses and score outputs
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         hit_pulse_r  <= '0;
         miss_pulse_r <= '0;
         score_r      <= '0;
         streak_r     <= 7'd0;
         mult_r       <= 3'd1;
      end else begin
         hit_pulse_r  <= hit_s ? sel_s : '0;
         miss_pulse_r <= (bad_s | pass_s) ? sel_s : '0;
         score_r      <= score_next_s;
         streak_r     <= streak_next_s;
         mult_r       <= mult_of(streak_next_s);
      end
   end

   assign bus.hit_pulse  = hit_pulse_r;
   assign bus.miss_pulse = miss_pulse_r;
   assign bus.score      = score_r;
   assign bus.streak     = streak_r;
   assign bus.multiplier = mult_r;
   assign bus.busy       = busy_r;

endmodule

// File: tb/tb_fret_hit_scorer.sv
// Directed bench for fret_hit_scorer: a 16-bit and an 8-bit score instance share
// stimulus; expected values are hand-computed per step.
module tb_fret_hit_scorer;
   import fret_hit_scorer_pkg::*;

   logic Clk = 1'b0;
   logic Reset = 1'b1;
   logic frame_clk = 1'b0;
   int   checks = 0;
   int   errors = 0;

   fret_hit_scorer_if #(.NUM_LANES(5), .SCORE_W(16)) bus16 ();
   fret_hit_scorer_if #(.NUM_LANES(5), .SCORE_W(8))  bus8 ();

   assign bus8.keycode    = bus16.keycode;
   assign bus8.note_y     = bus16.note_y;
   assign bus8.note_valid = bus16.note_valid;

   fret_hit_scorer #(.SCORE_W(16)) dut16 (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .bus       (bus16)
   );

   fret_hit_scorer #(.SCORE_W(8)) dut8 (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .bus       (bus8)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic set_note(input int lane, input int y, input logic v);
      bus16.note_y[lane*10 +: 10] = 10'(y);
      bus16.note_valid[lane]      = v;
   endtask

   task automatic new_note(input int lane, input int y);
      set_note(lane, 0, 1'b0);
      cyc(2);
      set_note(lane, y, 1'b1);
      cyc(1);
   endtask

   task automatic press(input logic [7:0] key);
      bus16.keycode = key;
      cyc(2);
      bus16.keycode = 8'h00;
      cyc(2);
   endtask

   // one VS pulse, observe 16 cycles, compare accumulated pulses
   task automatic frame_expect(input string tag, input logic [4:0] eh, input logic [4:0] em);
      logic [4:0] hits;
      logic [4:0] misses;
      int         n;
      hits = 5'b0;
      misses = 5'b0;
      n = 0;
      frame_clk = 1'b1;
      for (int c = 0; c < 16; c++) begin
         cyc(1);
         if (c == 4) frame_clk = 1'b0;
         hits   |= bus16.hit_pulse;
         misses |= bus16.miss_pulse;
         n += $countones(bus16.hit_pulse) + $countones(bus16.miss_pulse);
      end
      check({tag, "_hit"}, int'(hits), int'(eh));
      check({tag, "_miss"}, int'(misses), int'(em));
      check({tag, "_npulse"}, n, $countones(eh | em));
   endtask

   task automatic hit_lane(input int lane, input logic [7:0] key);
      new_note(lane, 420);
      press(key);
      frame_expect("hit", 5'b00001 << lane, 5'b00000);
   endtask

   initial begin
      logic found;
      bus16.keycode    = 8'h00;
      bus16.note_y     = '0;
      bus16.note_valid = '0;
      cyc(3);
      Reset = 1'b0;
      cyc(2);
      check("rst_score", int'(bus16.score), 0);
      check("rst_streak", int'(bus16.streak), 0);
      check("rst_mult", int'(bus16.multiplier), 1);
      check("rst_busy", int'(bus16.busy), 0);
      check("rst_hit", int'(bus16.hit_pulse), 0);
      check("rst_miss", int'(bus16.miss_pulse), 0);

      // held key triggers once, switching keys triggers the new lane
      bus16.keycode = 8'h04;
      cyc(2);
      frame_expect("held_first", 5'b00000, 5'b00001);
      frame_expect("held_again", 5'b00000, 5'b00000);
      bus16.keycode = 8'h16;
      cyc(2);
      frame_expect("key_change", 5'b00000, 5'b00010);
      bus16.keycode = 8'h00;
      cyc(2);

      // single lane-0 hit
      new_note(0, 420);
      press(8'h04);
      frame_expect("t1", 5'b00001, 5'b00000);
      check("t1_score", int'(bus16.score), 10);
      check("t1_streak", int'(bus16.streak), 1);
      check("t1_mult", int'(bus16.multiplier), 1);
      set_note(0, 0, 1'b0);
      press(8'h04);
      frame_expect("t1_break", 5'b00000, 5'b00001);
      check("t1_break_streak", int'(bus16.streak), 0);
      check("t1_break_score", int'(bus16.score), 10);

      // eleven lane-2 hits: multiplier steps to 2 at streak 10
      for (int k = 1; k <= 11; k++) begin
         hit_lane(2, 8'h07);
         if (k == 9) check("t2_mult9", int'(bus16.multiplier), 1);
         if (k == 10) begin
            check("t2_score10", int'(bus16.score), 110);
            check("t2_streak10", int'(bus16.streak), 10);
            check("t2_mult10", int'(bus16.multiplier), 2);
         end
         if (k == 11) begin
            check("t2_score11", int'(bus16.score), 130);
            check("t2_streak11", int'(bus16.streak), 11);
         end
      end
      set_note(2, 0, 1'b0);

      // passed note reported exactly once
      set_note(3, 470, 1'b1);
      cyc(2);
      frame_expect("t3_f1", 5'b00000, 5'b01000);
      frame_expect("t3_f2", 5'b00000, 5'b00000);
      frame_expect("t3_f3", 5'b00000, 5'b00000);
      check("t3_streak", int'(bus16.streak), 0);
      check("t3_score", int'(bus16.score), 130);
      set_note(3, 0, 1'b0);

      // bad press outside the zone breaks a streak of 5
      for (int k = 0; k < 5; k++) hit_lane(1, 8'h16);
      check("t4_streak5", int'(bus16.streak), 5);
      check("t4_score5", int'(bus16.score), 180);
      new_note(1, 300);
      press(8'h16);
      frame_expect("t4_bad", 5'b00000, 5'b00010);
      check("t4_streak", int'(bus16.streak), 0);
      check("t4_score", int'(bus16.score), 180);
      frame_expect("t4_quiet", 5'b00000, 5'b00000);
      set_note(1, 0, 1'b0);

      // 8-bit score saturates at 255 while the streak keeps counting
      for (int k = 0; k < 7; k++) hit_lane(4, 8'h0A);
      check("t5_score8_250", int'(bus8.score), 250);
      check("t5_streak7", int'(bus8.streak), 7);
      hit_lane(4, 8'h0A);
      check("t5_score8_sat", int'(bus8.score), 255);
      check("t5_score16", int'(bus16.score), 260);
      check("t5_streak8", int'(bus8.streak), 8);
      hit_lane(4, 8'h0A);
      check("t5_score8_hold", int'(bus8.score), 255);
      check("t5_streak9", int'(bus8.streak), 9);
      set_note(4, 0, 1'b0);

      // reset in the middle of a judge pass
      new_note(2, 420);
      press(8'h07);
      frame_clk = 1'b1;
      found = 1'b0;
      for (int c = 0; c < 12 && !found; c++) begin
         cyc(1);
         found = bus16.busy;
      end
      check("t6_busy_seen", int'(found), 1);
      if (found) begin
         @(posedge Clk);
         @(posedge Clk);
         #1;
         Reset = 1'b1;
         frame_clk = 1'b0;
         #2;
         check("t6_busy", int'(bus16.busy), 0);
         check("t6_score", int'(bus16.score), 0);
         @(negedge Clk);
         check("t6_streak", int'(bus16.streak), 0);
         check("t6_mult", int'(bus16.multiplier), 1);
         check("t6_hit", int'(bus16.hit_pulse), 0);
         check("t6_miss", int'(bus16.miss_pulse), 0);
         check("t6_score8", int'(bus8.score), 0);
      end
      frame_clk = 1'b0;
      cyc(2);
      Reset = 1'b0;
      cyc(2);
      frame_expect("t6_after", 5'b00000, 5'b00000);
      check("t6_after_score", int'(bus16.score), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
